// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the block-RAM arbiter.
// The optional power-up clear is enabled by defining BRAM_ARBITER_CLEAR_EN.
package bram_arbiter_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned DW_DEF    = 16;

  // All RAM bits are always written.
  localparam int unsigned RAM_MASK_ALL = 0;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// Requester-side bus of the block-RAM arbiter: packed per-requester request
// lanes, one-hot grant and one-hot read-response strobe.
interface bram_arbiter_if
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) ();

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/bram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N. Returns a one-hot grant and its encoded index.
module rr_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = idx_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    int unsigned j;
    j       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin sharing of one 256x16 SB_RAM40_4K among N_REQ requesters with a
// one-cycle read response. Define BRAM_ARBITER_CLEAR_EN to zero the RAM after reset.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bram_arbiter_if.slave        bus,
  output logic                 init_done_o,
  output logic                 ram_re_o,
  output logic                 ram_we_o,
  output logic [AW-1:0]        ram_raddr_o,
  output logic [AW-1:0]        ram_waddr_o,
  output logic [DW-1:0]        ram_wdata_o,
  output logic [DW-1:0]        ram_mask_o,
  input  logic [DW-1:0]        ram_rdata_i
);

  localparam int unsigned IdxW = idx_w(N_REQ);

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] rsp_id_q;
  logic            rd_pend_q;
  logic            init_done_q;

  logic [N_REQ-1:0] req_en;
  logic [N_REQ-1:0] gnt;
  logic [IdxW-1:0]  gnt_idx;
  logic             gnt_any;
  logic             win_we;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_wdata;
  logic             clr_active;
  logic [AW-1:0]    clr_addr;

`ifdef BRAM_ARBITER_CLEAR_EN
  localparam state_e ResetState = S_CLEAR;
  logic [AW-1:0] clr_addr_q;
  assign clr_active = (state_q == S_CLEAR);
  assign clr_addr   = clr_addr_q;
`else
  localparam state_e ResetState = S_RUN;
  assign clr_active = 1'b0;
  assign clr_addr   = '0;
`endif

  // Grants open only once init_done is registered, so nothing is accepted in reset.
  assign req_en = bus.req_valid & {N_REQ{init_done_q}};

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i   (req_en),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_any)
  );

  assign bus.req_ready = gnt;
  assign bus.rsp_rdata = ram_rdata_i;
  assign init_done_o   = init_done_q;
  assign ram_mask_o    = DW'(RAM_MASK_ALL);

  always_comb begin
    win_we    = bus.req_we[gnt_idx];
    win_addr  = bus.req_addr[32'(gnt_idx) * AW +: AW];
    win_wdata = bus.req_wdata[32'(gnt_idx) * DW +: DW];
  end

  always_comb begin
    ram_re_o    = gnt_any & ~win_we;
    ram_raddr_o = (gnt_any & ~win_we) ? win_addr : '0;
    ram_we_o    = (gnt_any & win_we) | (clr_active & rst_n);
    ram_waddr_o = '0;
    ram_wdata_o = '0;
    if (clr_active) begin
      ram_waddr_o = clr_addr;
    end else if (gnt_any & win_we) begin
      ram_waddr_o = win_addr;
      ram_wdata_o = win_wdata;
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (rd_pend_q) bus.rsp_valid[rsp_id_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == IdxW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef BRAM_ARBITER_CLEAR_EN
    if (state_q == S_CLEAR && clr_addr_q == '1) state_d = S_RUN;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ResetState;
      ptr_q       <= '0;
      rd_pend_q   <= 1'b0;
      rsp_id_q    <= '0;
      init_done_q <= 1'b0;
`ifdef BRAM_ARBITER_CLEAR_EN
      clr_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rd_pend_q   <= gnt_any & ~win_we;
      if (gnt_any) rsp_id_q <= gnt_idx;
      init_done_q <= (state_d == S_RUN);
`ifdef BRAM_ARBITER_CLEAR_EN
      if (clr_active) clr_addr_q <= clr_addr_q + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized bench for bram_arbiter: RAM model, behavioural scoreboard checked
// every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_bram_arbiter;
  import bram_arbiter_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef BRAM_ARBITER_CLEAR_EN
  localparam int unsigned INIT_CYC  = DEPTH;
  localparam int unsigned CLR_START = 0;
  localparam bit          CLEARED   = 1'b1;
`else
  localparam int unsigned INIT_CYC  = 1;
  localparam int unsigned CLR_START = DEPTH;
  localparam bit          CLEARED   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

  logic          init_done, ram_re, ram_we;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_wdata, ram_mask, ram_rdata;

  bram_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .init_done_o (init_done),
    .ram_re_o    (ram_re),
    .ram_we_o    (ram_we),
    .ram_raddr_o (ram_raddr),
    .ram_waddr_o (ram_waddr),
    .ram_wdata_o (ram_wdata),
    .ram_mask_o  (ram_mask),
    .ram_rdata_i (ram_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(int unsigned a);
    if (a == 32'h10) return 16'h1234;
    return DW'((a * 37) ^ 32'h5a5a);
  endfunction

  // SB_RAM40_4K model: registered read, RDATA valid after the RE edge.
  logic [DW-1:0] ram_mem [DEPTH];
  initial begin
    for (int a = 0; a < DEPTH; a++) ram_mem[a] = init_val(a);
    forever begin
      @(posedge clk);
      if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram_mem[ram_raddr];
    end
  end

  // Behavioural scoreboard, evaluated mid-cycle with inputs settled.
  logic [DW-1:0] shadow [DEPTH];
  initial begin
    int          m_ptr, m_pend_id, m_clr, g;
    bit          m_pend, m_init, found;
    logic [DW-1:0] m_pend_data;
    logic [N-1:0]  e_ready;
    logic [AW-1:0] a;
    m_ptr = 0; m_pend_id = 0; m_clr = CLR_START; m_pend = 0; m_init = 0;
    m_pend_data = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0; m_pend = 0; m_init = 0; m_clr = CLR_START;
        check("rst_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_init_done", init_done, 0);
        check("rst_ram_en", {ram_re, ram_we}, 0);
      end else begin
        check("rsp_valid", bus.rsp_valid, m_pend ? (1 << m_pend_id) : 0);
        if (m_pend) check("rsp_rdata", bus.rsp_rdata, m_pend_data);
        check("init_done", init_done, m_init);
        check("ram_mask", ram_mask, 0);
        found = 0; g = 0; e_ready = '0;
        if (m_clr < DEPTH) begin
          check("clr_we", {ram_re, ram_we}, 2'b01);
          check("clr_waddr", ram_waddr, m_clr);
          check("clr_wdata", ram_wdata, 0);
          shadow[m_clr] = '0;
        end else if (m_init) begin
          for (int k = 0; k < N; k++)
            if (!found && bus.req_valid[(m_ptr + k) % N]) begin
              found = 1; g = (m_ptr + k) % N;
            end
        end
        if (found) e_ready[g] = 1'b1;
        check("req_ready", bus.req_ready, e_ready);
        if (m_clr >= DEPTH) begin
          if (!found) check("idle_ram_en", {ram_re, ram_we}, 0);
          else begin
            a = bus.req_addr[g*AW +: AW];
            if (bus.req_we[g]) begin
              check("wr_en", {ram_re, ram_we}, 2'b01);
              check("wr_addr", ram_waddr, a);
              check("wr_data", ram_wdata, bus.req_wdata[g*DW +: DW]);
              shadow[a] = bus.req_wdata[g*DW +: DW];
            end else begin
              check("rd_en", {ram_re, ram_we}, 2'b10);
              check("rd_addr", ram_raddr, a);
              m_pend_data = shadow[a];
            end
          end
        end
        m_pend = found && !bus.req_we[g];
        if (found) begin
          m_pend_id = g;
          m_ptr = (g + 1) % N;
        end
        if (m_clr < DEPTH) m_clr++;
        m_init = (m_clr >= DEPTH);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic          r_valid [N];
  logic          r_we    [N];
  logic [AW-1:0] r_addr  [N];
  logic [DW-1:0] r_wdata [N];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]          = r_valid[i];
      bus.req_we[i]             = r_we[i];
      bus.req_addr[i*AW +: AW]  = r_addr[i];
      bus.req_wdata[i*DW +: DW] = r_wdata[i];
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    r_valid[i] = v; r_we[i] = we; r_addr[i] = a; r_wdata[i] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0, '0);
    drive();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (init_done === 1'b1) break;
      n++;
    end
    check(name, n, INIT_CYC);
    step();
  endtask

  initial begin
    logic [N-1:0] taken;
    int           density;
    idle_all();
    repeat (3) step();
    @(negedge clk);
    check("lit_reset_init", init_done, 0);
    check("lit_reset_ready", bus.req_ready, 0);
    step();
    rst_n = 1'b1;
    wait_init("lit_init_latency");

    // Requester 2 reads 0x10.
    set_req(2, 1'b1, 1'b0, 8'h10, '0); drive();
    @(negedge clk); check("lit_rd2_ready", bus.req_ready, 4'b0100);
    step(); idle_all();
    @(negedge clk);
    check("lit_rd2_rsp_valid", bus.rsp_valid, 4'b0100);
    check("lit_rd2_rdata", bus.rsp_rdata, CLEARED ? 16'h0000 : 16'h1234);

    // Requester 0 writes 0xBEEF to 0x05, requester 1 reads it back next cycle.
    step(); set_req(0, 1'b1, 1'b1, 8'h05, 16'hBEEF); drive();
    @(negedge clk); check("lit_wr0_ready", bus.req_ready, 4'b0001);
    step(); idle_all(); set_req(1, 1'b1, 1'b0, 8'h05, '0); drive();
    @(negedge clk); check("lit_rd1_ready", bus.req_ready, 4'b0010);
    step(); idle_all();
    @(negedge clk);
    check("lit_raw_rsp_valid", bus.rsp_valid, 4'b0010);
    check("lit_raw_rdata", bus.rsp_rdata, 16'hBEEF);

    // Only 3, then 3 and 0: pointer wraps to 0 with no idle cycle.
    step(); set_req(3, 1'b1, 1'b0, 8'h20, '0); drive();
    @(negedge clk); check("lit_wrap_g3", bus.req_ready, 4'b1000);
    step(); set_req(0, 1'b1, 1'b0, 8'h21, '0); drive();
    @(negedge clk); check("lit_wrap_g0", bus.req_ready, 4'b0001);

    // Reset right after a read grant discards the response.
    step(); idle_all(); set_req(1, 1'b1, 1'b0, 8'h10, '0); drive();
    @(negedge clk); check("lit_mid_ready", bus.req_ready, 4'b0010);
    step(); rst_n = 1'b0; idle_all();
    @(negedge clk); check("lit_mid_rsp_valid", bus.rsp_valid, 0);
    step(); step(); rst_n = 1'b1;
    wait_init("lit_init_latency2");

    // All four continuously valid from ptr=0.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(8'h30 + i), '0);
    drive();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("lit_rr_ready", bus.req_ready, 1 << (c % N));
      if (c > 0) check("lit_rr_rsp", bus.rsp_valid, 1 << ((c - 1) % N));
      step();
    end
    idle_all();

    // Boundary addresses after clear (or INIT contents otherwise).
    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] ba;
      ba = (k == 0) ? 8'h00 : (k == 1) ? 8'h7F : 8'hFF;
      set_req(0, 1'b1, 1'b0, ba, '0); drive();
      step(); idle_all();
      @(negedge clk);
      check("lit_edge_rdata", bus.rsp_rdata, CLEARED ? 16'h0000 : init_val(ba));
      step();
    end

    // Randomized traffic; requests hold until granted, some drop early.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      taken = bus.req_valid & bus.req_ready;
      step();
      density = (c < 1500) ? 90 : 40;
      for (int i = 0; i < N; i++) begin
        if (taken[i] || !r_valid[i]) begin
          r_valid[i] = ($urandom_range(99) < density);
          r_we[i]    = 1'($urandom_range(1));
          r_addr[i]  = ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(7));
          r_wdata[i] = DW'($urandom);
        end else if ($urandom_range(19) == 0) begin
          r_valid[i] = 1'b0;
        end
      end
      drive();
    end
    idle_all();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one 256x16 ICE40 block RAM (SB_RAM40_4K, mode 0, both ports) between N_REQ requesters, e.g. per-channel delay lines and the calibration table.
- Uses a round-robin grant with at most one access (read or write) per clock.
- Read data returns with fixed latency; each response carries the index of its requester.
- Sits between the DSP cores and the RAM primitive; it is the only driver of the RAM ports.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- AW, 8, address width (RAM depth 2^AW = 256)
- DW, 16, data width

Ports:
- clk  in  1  system clock; RAM RCLK/WCLK tied to clk
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  in  N_REQ*DW  packed write data
- req_ready  out  N_REQ  one-hot grant; the transfer happens when valid&&ready
- rsp_valid  out  N_REQ  one-hot read-response strobe
- rsp_rdata  out  DW  read data, valid while any rsp_valid bit is set
- init_done  out  1  arbiter is accepting requests
- ram_re, ram_we  out  1  RAM RE/WE; RCLKE/WCLKE tied high externally
- ram_raddr, ram_waddr  out  AW  RAM addresses (upper RADDR/WADDR bits tied 0)
- ram_wdata  out  DW  RAM write data
- ram_mask  out  DW  RAM MASK, constant 0 (all bits written)
- ram_rdata  in  DW  RAM RDATA

Behaviour:
- Reset values, asserted asynchronously on rst_n low:
  - ptr=0, state=S_CLEAR if clear is enabled else S_RUN
  - rsp_valid=0, rsp_id=0, init_done=0
  - ram_re=0, ram_we=0
  - req_ready=0 (combinational, gated by state)
- Grant (combinational, S_RUN only):
  - Search req_valid starting at index ptr, wrapping modulo N_REQ.
  - The first set bit wins and gets req_ready[g]=1. At most one bit of req_ready is high.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer: on any grant g, ptr <= (g+1) mod N_REQ at the clock edge. With no request, ptr holds.
- Fairness: a requester holding valid high is granted within N_REQ cycles.
- Access issue:
  - RAM address, data and enables are driven combinationally from the winner in the grant cycle.
  - The RAM samples them at that edge.
  - Write: ram_we=1, ram_waddr/ram_wdata from the winner, ram_re=0.
  - Read: ram_re=1, ram_raddr from the winner, ram_we=0.
- Read latency:
  - Grant at edge k; RAM data is present after edge k.
  - The registered flag rd_pend and rsp_id=g are set at edge k.
  - In cycle k+1: rsp_valid[rsp_id]=1 for exactly one cycle, and rsp_rdata=ram_rdata passes through.
  - Back-to-back reads give one response per cycle.
- Read after write to the same address on consecutive grants returns the new data. RAM write and read are on separate edges.
- No RAM port is enabled in an idle cycle.
- Requesters hold req_* stable until granted. Dropping valid before the grant is legal; no access occurs.
- Reset mid-read: the pending response is discarded and rsp_valid stays 0.
- init_done=1 in S_RUN.

Optional Feature:
- Macro: BRAM_ARBITER_CLEAR_EN
- Defined: after reset the FSM sits in S_CLEAR.
  - Counter clr_addr runs from 0 to 2^AW-1, one write per cycle: ram_we=1, ram_wdata=0.
  - req_ready=0 and init_done=0 throughout.
  - After writing address 255 (2^AW-1) the FSM moves to S_RUN. init_done rises on the cycle after the last clear write, i.e. 256 cycles after reset release.
- Undefined: no S_CLEAR state and no counter; S_RUN and init_done=1 from the first clock after reset release. RAM contents come from INIT_* parameters.

Decomposition:
- Package bram_arbiter_pkg:
  - State encodings S_CLEAR/S_RUN
  - Defaults for N_REQ/AW/DW
  - Constant RAM_MASK_ALL = 0
- Sub-module rr_arbiter: N_REQ-wide request vector in, ptr in, one-hot grant plus encoded index out. Purely combinational. Reused by other shared-resource blocks.

Test Plan:
- Reset release, macro off: init_done=1 next cycle. Requester 2 reads addr 0x10 with INIT value 0x1234 -> rsp_valid=4'b0100 and rsp_rdata=0x1234 one cycle after the grant.
- Requester 0 writes 0xBEEF to 0x05, then requester 1 reads 0x05 on the next cycle -> rsp_valid[1] with 0xBEEF.
- All four requesters valid continuously with ptr=0 -> grant order 0,1,2,3,0,... One-hot req_ready every cycle; reads give 1 response per cycle.
- Only requester 3 valid, then 3 and 0 -> grants 3 then 0 (pointer wraps); no idle cycle between them.
- rst_n pulsed low the cycle after a read grant -> rsp_valid remains 0, ptr=0 after release.
- BRAM_ARBITER_CLEAR_EN defined, INIT_0 nonzero -> req_ready=0 for 256 cycles, then init_done=1. Reads of 0x00, 0x7F and 0xFF return 0x0000.
